// File: rtl/wash_setup.sv
// Order-entry front end for the washing-machine controller: BCD balance entry,
// mode and time selection with a cost check, then a READY hand-off to the sequencer.
module wash_setup #(
    parameter int DIGITS   = 3,
    parameter int MODES    = 4,
    parameter int MAX_MIN  = 20,
    parameter int TICK_DIV = 66000000,
    parameter int BAL_W    = 11
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [DIGITS-1:0]          sw,
    input  logic                       sign_sw,
    input  logic                       btn_inc,
    input  logic                       btn_ok,
    input  logic                       btn_back,
    input  logic                       done,
    output logic [3:0]                 state_led,
    output logic [BAL_W-1:0]           balance,
    output logic [$clog2(MODES)-1:0]   mode,
    output logic [6:0]                 minutes,
    output logic [BAL_W-1:0]           cost,
    output logic                       start,
    output logic                       err,
    output logic [4*(DIGITS+1)-1:0]    disp
);

    localparam int MW = $clog2(MODES);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = 4 * (DIGITS + 1);

    typedef enum logic [3:0] {
        S_BAL   = 4'b0001,
        S_MODE  = 4'b0010,
        S_TIME  = 4'b0100,
        S_READY = 4'b1000
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        digit_q [DIGITS];
    logic [3:0]        digit_d [DIGITS];
    logic [3:0]        digit_inc [DIGITS];
    logic              neg_q, neg_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [6:0]        edit_q, edit_d;
    logic [BAL_W-1:0]  balance_q, balance_d;
    logic [MW-1:0]     mode_q, mode_d;
    logic [6:0]        minutes_q, minutes_d;
    logic              err_q, err_d;
    logic [2:0]        btn_cur_q, btn_cur_d;
    logic [2:0]        btn_prev_q, btn_prev_d;

    logic [2:0]        press;
    logic              press_inc, press_ok, press_back;
    logic              tick_wrap;
    logic [BAL_W-1:0]  entry;
    logic [6:0]        cost_min;
    logic [MW-1:0]     cost_mode;
    logic [BAL_W-1:0]  cost_w;
    logic [7:0]        time_sum;
    logic [6:0]        time_next;
    logic [DW-1:0]     disp_c;
    logic [BAL_W-1:0]  rem;

    // Button history is {back, ok, inc}; a press is a rising edge of the registered level.
    assign press      = btn_cur_q & ~btn_prev_q;
    assign press_inc  = press[0];
    assign press_ok   = press[1];
    assign press_back = press[2];

    assign tick_wrap = (tick_q == TW'(TICK_DIV - 1));

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign digit_inc[gi] = (digit_q[gi] == 4'd9) ? 4'd0 : digit_q[gi] + 4'd1;
        end
    endgenerate

    always_comb begin
        entry = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            entry = entry * BAL_W'(10) + BAL_W'(digit_q[i]);
        end
    end

    // Cost follows whichever of mode/minutes is currently being edited.
    assign cost_min  = (state_q == S_TIME) ? edit_q : minutes_q;
    assign cost_mode = (state_q == S_MODE) ? edit_q[MW-1:0] : mode_q;
    assign cost_w    = BAL_W'(cost_min) * (BAL_W'(cost_mode) + BAL_W'(1));

    assign time_sum  = {1'b0, edit_q} + (sw[0] ? 8'd10 : 8'd1);
    assign time_next = (time_sum > 8'(MAX_MIN)) ? 7'd0 : time_sum[6:0];

    always_comb begin
        disp_c = {(DIGITS + 1){4'd11}};
        rem    = cost_w;
        case (state_q)
            S_BAL: begin
                for (int i = 0; i < DIGITS; i++) begin
                    disp_c[4*i +: 4] = digit_q[i];
                end
                disp_c[DW-4 +: 4] = neg_q ? 4'd10 : 4'd11;
            end
            S_MODE: begin
                disp_c[3:0] = 4'(edit_q[MW-1:0]);
            end
            S_TIME: begin
                disp_c[3:0]       = 4'(edit_q % 7'd10);
                disp_c[7:4]       = 4'(edit_q / 7'd10);
                disp_c[DW-4 +: 4] = 4'(mode_q);
            end
            S_READY: begin
                for (int i = 0; i < DIGITS; i++) begin
                    disp_c[4*i +: 4] = 4'(rem % BAL_W'(10));
                    rem = rem / BAL_W'(10);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        for (int i = 0; i < DIGITS; i++) begin
            digit_d[i] = digit_q[i];
        end
        neg_d      = neg_q;
        tick_d     = tick_q;
        edit_d     = edit_q;
        balance_d  = balance_q;
        mode_d     = mode_q;
        minutes_d  = minutes_q;
        err_d      = err_q;
        btn_cur_d  = btn_cur_q;
        btn_prev_d = btn_prev_q;

        if (en) begin
            err_d      = 1'b0;
            btn_cur_d  = {btn_back, btn_ok, btn_inc};
            btn_prev_d = btn_cur_q;
            case (state_q)
                S_BAL: begin
                    if (tick_wrap) begin
                        tick_d = '0;
                        for (int i = 0; i < DIGITS; i++) begin
                            if (sw[i]) digit_d[i] = digit_inc[i];
                        end
                        if (sign_sw) neg_d = ~neg_q;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                    // Only a clean, non-negative entry with all switches parked is accepted.
                    if (press_ok) begin
                        if ((|sw) || sign_sw || neg_q) begin
                            for (int i = 0; i < DIGITS; i++) begin
                                digit_d[i] = 4'd0;
                            end
                            neg_d = 1'b0;
                            err_d = 1'b1;
                        end else begin
                            balance_d = entry;
                            state_d   = S_MODE;
                            edit_d    = 7'd0;
                            tick_d    = '0;
                        end
                    end
                end
                S_MODE: begin
                    if (press_back) begin
                        state_d = S_BAL;
                    end else if (press_ok) begin
                        mode_d  = edit_q[MW-1:0];
                        state_d = S_TIME;
                        edit_d  = 7'd0;
                    end else if (press_inc) begin
                        edit_d = (edit_q == 7'(MODES - 1)) ? 7'd0 : edit_q + 7'd1;
                    end
                end
                S_TIME: begin
                    if (press_back) begin
                        state_d = S_MODE;
                        edit_d  = 7'(mode_q);
                    end else if (press_ok) begin
                        if ((edit_q == 7'd0) || (cost_w > balance_q)) begin
                            err_d = 1'b1;
                        end else begin
                            minutes_d = edit_q;
                            state_d   = S_READY;
                        end
                    end else if (press_inc) begin
                        edit_d = time_next;
                    end
                end
                S_READY: begin
                    if (done) begin
                        balance_d = balance_q - cost_w;
                        state_d   = S_MODE;
                        edit_d    = 7'(mode_q);
                    end
                end
                default: state_d = S_BAL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_BAL;
            for (int i = 0; i < DIGITS; i++) begin
                digit_q[i] <= 4'd0;
            end
            neg_q      <= 1'b0;
            tick_q     <= '0;
            edit_q     <= 7'd0;
            balance_q  <= '0;
            mode_q     <= '0;
            minutes_q  <= 7'd0;
            err_q      <= 1'b0;
            btn_cur_q  <= 3'b000;
            btn_prev_q <= 3'b000;
        end else begin
            state_q    <= state_d;
            for (int i = 0; i < DIGITS; i++) begin
                digit_q[i] <= digit_d[i];
            end
            neg_q      <= neg_d;
            tick_q     <= tick_d;
            edit_q     <= edit_d;
            balance_q  <= balance_d;
            mode_q     <= mode_d;
            minutes_q  <= minutes_d;
            err_q      <= err_d;
            btn_cur_q  <= btn_cur_d;
            btn_prev_q <= btn_prev_d;
        end
    end

    assign state_led = state_q;
    assign balance   = balance_q;
    assign mode      = mode_q;
    assign minutes   = minutes_q;
    assign cost      = cost_w;
    assign start     = (state_q == S_READY);
    assign err       = err_q;
    assign disp      = disp_c;

endmodule

// File: tb/tb_wash_setup.sv
// Scoreboard bench for wash_setup: expected output snapshots are queued with each
// stimulus step and compared against the DUT snapshot taken at the same point.
module tb_wash_setup;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [2:0]  sw = 3'b000;
    logic        sign_sw = 1'b0;
    logic        btn_inc = 1'b0;
    logic        btn_ok = 1'b0;
    logic        btn_back = 1'b0;
    logic        done = 1'b0;
    logic [3:0]  state_led;
    logic [10:0] balance;
    logic [1:0]  mode;
    logic [6:0]  minutes;
    logic [10:0] cost;
    logic        start;
    logic        err;
    logic [15:0] disp;

    localparam logic [3:0] ST_BAL   = 4'b0001;
    localparam logic [3:0] ST_MODE  = 4'b0010;
    localparam logic [3:0] ST_TIME  = 4'b0100;
    localparam logic [3:0] ST_READY = 4'b1000;

    wash_setup #(
        .DIGITS(3), .MODES(4), .MAX_MIN(20), .TICK_DIV(4), .BAL_W(11)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .sw(sw), .sign_sw(sign_sw),
        .btn_inc(btn_inc), .btn_ok(btn_ok), .btn_back(btn_back), .done(done),
        .state_led(state_led), .balance(balance), .mode(mode), .minutes(minutes),
        .cost(cost), .start(start), .err(err), .disp(disp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  st;
        logic [10:0] bal;
        logic [1:0]  md;
        logic [6:0]  mn;
        logic [10:0] cst;
        logic        stt;
        logic        er;
        logic [15:0] dsp;
    } snap_t;

    snap_t exp_q[$];
    snap_t obs_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    function automatic snap_t mk(input logic [3:0] st, input int bal, input int md, input int mn,
                                 input int cst, input logic stt, input logic er, input logic [15:0] d);
        snap_t s;
        s.st  = st;
        s.bal = 11'(bal);
        s.md  = 2'(md);
        s.mn  = 7'(mn);
        s.cst = 11'(cst);
        s.stt = stt;
        s.er  = er;
        s.dsp = d;
        return s;
    endfunction

    function automatic snap_t sample();
        snap_t s;
        s.st  = state_led;
        s.bal = balance;
        s.md  = mode;
        s.mn  = minutes;
        s.cst = cost;
        s.stt = start;
        s.er  = err;
        s.dsp = disp;
        return s;
    endfunction

    task automatic rec(input string nm, input snap_t e);
        name_q.push_back(nm);
        exp_q.push_back(e);
        obs_q.push_back(sample());
    endtask

    // b = {back, ok, inc}; held one cycle, effect visible on return.
    task automatic press(input logic [2:0] b);
        {btn_back, btn_ok, btn_inc} = b;
        @(posedge clk); #1;
        {btn_back, btn_ok, btn_inc} = 3'b000;
        @(posedge clk); #1;
    endtask

    // Any window of 4n edges contains exactly n tick wraps when TICK_DIV=4.
    task automatic hold_sw(input logic [2:0] pat, input int n);
        sw = pat;
        repeat (4 * n) @(posedge clk);
        #1;
        sw = 3'b000;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rec("reset_state", mk(ST_BAL, 0, 0, 0, 0, 0, 0, 16'hB000));
        rst = 1'b1;
        while (exp_q.size() > 0) begin
            snap_t e, o; string nm;
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL %s: got %h want %h", nm, o, e); end
            else $display("check %s: ok", nm);
        end
    endtask

    task automatic test_tick();
        sw = 3'b101;
        repeat (3) @(posedge clk); #1;
        rec("tick_before_first", mk(ST_BAL, 0, 0, 0, 0, 0, 0, 16'hB000));
        @(posedge clk); #1;
        rec("tick_first", mk(ST_BAL, 0, 0, 0, 0, 0, 0, 16'hB101));
        repeat (8) @(posedge clk); #1;
        rec("tick_b303", mk(ST_BAL, 0, 0, 0, 0, 0, 0, 16'hB303));
        sw = 3'b000;
        while (exp_q.size() > 0) begin
            snap_t e, o; string nm;
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL %s: got %h want %h", nm, o, e); end
            else $display("check %s: ok", nm);
        end
    endtask

    task automatic test_bal_entry();
        hold_sw(3'b111, 2);
        hold_sw(3'b100, 6);
        rec("bal_125", mk(ST_BAL, 0, 0, 0, 0, 0, 0, 16'hB125));
        sign_sw = 1'b1;
        repeat (4) @(posedge clk); #1;
        sign_sw = 1'b0;
        rec("bal_neg", mk(ST_BAL, 0, 0, 0, 0, 0, 0, 16'hA125));
        press(3'b010);
        rec("bal_reject", mk(ST_BAL, 0, 0, 0, 0, 0, 1, 16'hB000));
        @(posedge clk); #1;
        rec("err_one_cycle", mk(ST_BAL, 0, 0, 0, 0, 0, 0, 16'hB000));
        hold_sw(3'b111, 1);
        hold_sw(3'b011, 1);
        hold_sw(3'b001, 3);
        press(3'b010);
        rec("bal_accept", mk(ST_MODE, 125, 0, 0, 0, 0, 0, 16'hBBB0));
        while (exp_q.size() > 0) begin
            snap_t e, o; string nm;
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL %s: got %h want %h", nm, o, e); end
            else $display("check %s: ok", nm);
        end
    endtask

    task automatic test_mode();
        repeat (5) press(3'b001);
        rec("mode_wrap", mk(ST_MODE, 125, 0, 0, 0, 0, 0, 16'hBBB1));
        btn_inc = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        btn_inc = 1'b0;
        @(posedge clk); #1;
        rec("mode_hold_once", mk(ST_MODE, 125, 0, 0, 0, 0, 0, 16'hBBB2));
        repeat (3) press(3'b001);
        press(3'b010);
        rec("mode_ok", mk(ST_TIME, 125, 1, 0, 0, 0, 0, 16'h1B00));
        while (exp_q.size() > 0) begin
            snap_t e, o; string nm;
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL %s: got %h want %h", nm, o, e); end
            else $display("check %s: ok", nm);
        end
    endtask

    task automatic test_time();
        press(3'b100);
        rec("time_back_mode", mk(ST_MODE, 125, 1, 0, 0, 0, 0, 16'hBBB1));
        press(3'b100);
        rec("mode_back_bal", mk(ST_BAL, 125, 1, 0, 0, 0, 0, 16'hB125));
        hold_sw(3'b111, 1);
        hold_sw(3'b101, 4);
        hold_sw(3'b100, 4);
        rec("bal_030", mk(ST_BAL, 125, 1, 0, 0, 0, 0, 16'hB030));
        press(3'b010);
        press(3'b001);
        press(3'b010);
        rec("time_entry", mk(ST_TIME, 30, 1, 0, 0, 0, 0, 16'h1B00));
        sw = 3'b001;
        press(3'b001);
        rec("time_inc10", mk(ST_TIME, 30, 1, 0, 20, 0, 0, 16'h1B10));
        sw = 3'b000;
        repeat (6) press(3'b001);
        rec("time_16", mk(ST_TIME, 30, 1, 0, 32, 0, 0, 16'h1B16));
        press(3'b010);
        rec("time_over_bal", mk(ST_TIME, 30, 1, 0, 32, 0, 1, 16'h1B16));
        sw = 3'b001;
        press(3'b001);
        rec("time_wrap26", mk(ST_TIME, 30, 1, 0, 0, 0, 0, 16'h1B00));
        sw = 3'b000;
        press(3'b010);
        rec("time_zero", mk(ST_TIME, 30, 1, 0, 0, 0, 1, 16'h1B00));
        sw = 3'b001;
        repeat (2) press(3'b001);
        rec("time_max", mk(ST_TIME, 30, 1, 0, 40, 0, 0, 16'h1B20));
        sw = 3'b000;
        press(3'b001);
        rec("time_wrap21", mk(ST_TIME, 30, 1, 0, 0, 0, 0, 16'h1B00));
        press(3'b100);
        press(3'b010);
        sw = 3'b001;
        press(3'b001);
        sw = 3'b000;
        repeat (5) press(3'b001);
        rec("time_15", mk(ST_TIME, 30, 1, 0, 30, 0, 0, 16'h1B15));
        press(3'b010);
        rec("ready_enter", mk(ST_READY, 30, 1, 15, 30, 1, 0, 16'hB030));
        while (exp_q.size() > 0) begin
            snap_t e, o; string nm;
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL %s: got %h want %h", nm, o, e); end
            else $display("check %s: ok", nm);
        end
    endtask

    task automatic test_back_to_back();
        press(3'b010);
        press(3'b100);
        rec("ready_ignore_btn", mk(ST_READY, 30, 1, 15, 30, 1, 0, 16'hB030));
        done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
        rec("ready_done", mk(ST_MODE, 0, 1, 15, 30, 0, 0, 16'hBBB1));
        press(3'b110);
        rec("back_over_ok", mk(ST_BAL, 0, 1, 15, 30, 0, 0, 16'hB030));
        while (exp_q.size() > 0) begin
            snap_t e, o; string nm;
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL %s: got %h want %h", nm, o, e); end
            else $display("check %s: ok", nm);
        end
    endtask

    task automatic test_enable();
        en = 1'b0;
        sw = 3'b111;
        sign_sw = 1'b1;
        done = 1'b1;
        for (int i = 0; i < 100; i++) begin
            btn_ok   = (i % 2) == 1;
            btn_back = (i % 4) == 2;
            btn_inc  = (i % 3) == 1;
            @(posedge clk); #1;
        end
        {btn_back, btn_ok, btn_inc} = 3'b000;
        sw = 3'b000;
        sign_sw = 1'b0;
        done = 1'b0;
        rec("en_freeze", mk(ST_BAL, 0, 1, 15, 30, 0, 0, 16'hB030));
        en = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        rec("en_resume", mk(ST_BAL, 0, 1, 15, 30, 0, 0, 16'hB030));
        while (exp_q.size() > 0) begin
            snap_t e, o; string nm;
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL %s: got %h want %h", nm, o, e); end
            else $display("check %s: ok", nm);
        end
    endtask

    task automatic test_reset_ready();
        press(3'b010);
        press(3'b010);
        press(3'b001);
        press(3'b010);
        rec("ready_second", mk(ST_READY, 30, 0, 1, 1, 1, 0, 16'hB001));
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        rec("async_reset", mk(ST_BAL, 0, 0, 0, 0, 0, 0, 16'hB000));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rec("after_reset", mk(ST_BAL, 0, 0, 0, 0, 0, 0, 16'hB000));
        while (exp_q.size() > 0) begin
            snap_t e, o; string nm;
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL %s: got %h want %h", nm, o, e); end
            else $display("check %s: ok", nm);
        end
    endtask

    initial begin
        test_reset();
        test_tick();
        test_bal_entry();
        test_mode();
        test_time();
        test_back_to_back();
        test_enable();
        test_reset_ready();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wash_setup.md
# wash_setup

Parametrised order-entry front end for the washing-machine controller. It runs a four-stage entry sequence: signed BCD balance entry on DIP switches, then wash-mode selection, then wash-time entry, then a READY hand-off to the wash sequencer. It replaces level-sensitive button handling with edge-detected presses, checks cost against balance, and drives a packed digit bus for the 7-segment scanners.

## Interface
- DIGITS, 3, number of BCD balance digits (1–4)
- MODES, 4, number of wash modes (2–8); mode m costs (m+1) per minute
- MAX_MIN, 20, maximum wash minutes (≤99)
- TICK_DIV, 66000000, clk cycles per switch-increment tick
- BAL_W, 11, binary width of balance and cost; must hold 10^DIGITS−1 and MAX_MIN·MODES
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- en  in  1  block enable; low freezes all state, counters and outputs
- sw  in  DIGITS  digit-increment switches, sw[0] = units
- sign_sw  in  1  sign toggle switch
- btn_inc  in  1  increment button, synchronous level, one action per rising edge
- btn_ok  in  1  confirm button, one action per rising edge
- btn_back  in  1  back button, one action per rising edge
- done  in  1  wash sequencer finished, level
- state_led  out  4  one-hot state: BAL=0001, MODE=0010, TIME=0100, READY=1000
- balance  out  BAL_W  committed balance, binary
- mode  out  $clog2(MODES)  committed mode
- minutes  out  7  committed wash minutes
- cost  out  BAL_W  minutes·(mode+1) for the current edit values
- start  out  1  high throughout READY
- err  out  1  one-cycle pulse on a rejected confirm
- disp  out  4·(DIGITS+1)  digit codes, low nibble = rightmost; 0–9 digit, 10 = minus, 11 = blank

## Operation
- Press detection: each button is registered once; press = current & ~previous. Only presses act.
- Priority within a cycle: back > ok > inc.
- BAL:
  - Tick counter counts 0..TICK_DIV−1 and wraps.
  - On wrap, each digit i with sw[i]=1 increments mod 10.
  - On wrap, if sign_sw=1, the neg flag toggles.
  - disp: digits; top nibble is 10 if neg, else 11.
  - ok with any sw high, sign_sw high or neg=1: clear digits and neg, pulse err, stay in BAL.
  - Otherwise: balance ← Σ digit_i·10^i, enter MODE with the edit value cleared to 0. back has no effect.
- MODE:
  - inc: edit value +1, wrapping MODES−1 → 0.
  - ok: mode ← edit value, enter TIME with the edit value cleared.
  - back: enter BAL; digits are retained.
  - disp: low nibble = edit value; others blank.
- TIME:
  - inc with sw[0]=1: +10; with sw[0]=0: +1.
  - Any result > MAX_MIN wraps to 0.
  - ok with edit value = 0 or cost > balance: pulse err, stay in TIME.
  - ok otherwise: minutes ← edit value, enter READY.
  - back: enter MODE.
  - disp: two-digit minutes (units, tens), top nibble = mode, rest blank.
- READY:
  - start=1; buttons are ignored; disp shows cost with the top nibble blank.
  - On done=1: balance ← balance − cost, enter MODE with the edit value = mode.
- en=0: no register changes, including button history. Presses that span an en low→high transition are not re-detected.

## Timing
- Reset values:
  - state BAL; state_led=0001.
  - balance, mode, minutes, digits, neg, edit value, tick counter all 0.
  - start=0, err=0.
  - disp: digits 0, top nibble 11.
- A button rising at clk edge k produces its state/register effect at edge k+1; err is high for exactly the cycle after that edge.
- start rises the cycle after the accepting ok edge and falls the cycle after done is sampled high.
- Updates to cost and disp are combinational from registers, so zero extra latency.
- Tick: first increment occurs TICK_DIV cycles after reset or after leaving BAL. The counter is cleared on every BAL exit.
- Asynchronous rst mid-READY drops start immediately and does not apply the balance debit.

## Test plan
- TICK_DIV=4: hold sw[0] and sw[2] high for 12 cycles in BAL → units and hundreds digits = 3, tens = 0; disp = 0xB303.
- Digits 1,2,5 (balance 125), sign_sw toggled to negative, ok → err pulse, digits cleared, stays BAL. Re-enter 125, ok → balance=125, state_led=0010.
- MODE: 5 inc presses with MODES=4 → edit value 1. Hold inc high for 10 cycles → only one increment. ok → mode=1, TIME.
- TIME with balance=30, mode=1: sw[0]=1 inc once (10), sw[0]=0 inc 6 times (16) → cost 32, ok → err. back, inc… set 15 → ok → READY, start=1 next cycle.
- READY: pulse done → balance=0, state MODE, start=0. Assert btn_ok and btn_back in the same cycle in MODE → BAL.
- en=0 for 100 cycles with sw high and button edges → no change. Assert rst mid-READY → all reset values.
